// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational 4-bit ALU between two requesters.
// Operands are registered toward the ALU and held for LAT cycles before the result is captured.
module alu_share_ctrl #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] o0,
  input  logic [1:0] o1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_o,
  input  logic [7:0] alu_p,
  output logic       busy,
  output logic [7:0] ops
);

  // state | meaning
  // IDLE  | arbitrate between eligible requesters
  // EXEC  | ALU inputs held while the result settles
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_o_q, alu_o_d;
  logic [7:0] r0_q, r0_d;
  logic [7:0] r1_q, r1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic [7:0] ops_q, ops_d;

  logic       el0, el1, win;

  // A port in its done cycle is masked so a lingering req is not re-granted at once.
  assign el0 = req0 & ~done0_q;
  assign el1 = req1 & ~done1_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_o_d = alu_o_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    ops_d   = ops_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (el0 || el1) begin
          win     = (el0 && el1) ? prio_q : el1;
          state_d = EXEC;
          owner_d = win;
          cnt_d   = CNT_INIT;
          alu_a_d = win ? a1 : a0;
          alu_b_d = win ? b1 : b0;
          alu_o_d = win ? o1 : o0;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q) begin
            r1_d    = alu_p;
            done1_d = 1'b1;
          end else begin
            r0_d    = alu_p;
            done0_d = 1'b1;
          end
          prio_d  = ~owner_q;
          ops_d   = ops_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 4'd0;
      alu_a_q <= 4'd0;
      alu_b_q <= 4'd0;
      alu_o_q <= 2'd0;
      r0_q    <= 8'd0;
      r1_q    <= 8'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      ops_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_o_q <= alu_o_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      ops_q   <= ops_d;
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign r0    = r0_q;
  assign r1    = r1_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_o = alu_o_q;
  assign busy  = (state_q == EXEC);
  assign ops   = ops_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: one instance with LAT=1 and one with LAT=4,
// each driven by a small combinational ALU model.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] o);
    case (o)
      2'b00:   return {4'b0, a} + {4'b0, b};
      2'b01:   return {4'b0, a} - {4'b0, b};
      2'b10:   return {4'b0, a} * {4'b0, b};
      default: return {a, b};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // LAT=1 instance
  logic       u1_rst, u1_req0, u1_req1, u1_done0, u1_done1, u1_busy;
  logic [3:0] u1_a0, u1_b0, u1_a1, u1_b1, u1_alu_a, u1_alu_b;
  logic [1:0] u1_o0, u1_o1, u1_alu_o;
  logic [7:0] u1_r0, u1_r1, u1_alu_p, u1_ops;
  assign u1_alu_p = alu_ref(u1_alu_a, u1_alu_b, u1_alu_o);

  alu_share_ctrl #(.LAT(1)) u1 (
    .clk(clk), .rst(u1_rst), .req0(u1_req0), .req1(u1_req1),
    .a0(u1_a0), .b0(u1_b0), .a1(u1_a1), .b1(u1_b1), .o0(u1_o0), .o1(u1_o1),
    .done0(u1_done0), .done1(u1_done1), .r0(u1_r0), .r1(u1_r1),
    .alu_a(u1_alu_a), .alu_b(u1_alu_b), .alu_o(u1_alu_o), .alu_p(u1_alu_p),
    .busy(u1_busy), .ops(u1_ops)
  );

  // LAT=4 instance
  logic       u4_rst, u4_req0, u4_req1, u4_done0, u4_done1, u4_busy;
  logic [3:0] u4_a0, u4_b0, u4_a1, u4_b1, u4_alu_a, u4_alu_b;
  logic [1:0] u4_o0, u4_o1, u4_alu_o;
  logic [7:0] u4_r0, u4_r1, u4_alu_p, u4_ops;
  assign u4_alu_p = alu_ref(u4_alu_a, u4_alu_b, u4_alu_o);

  alu_share_ctrl #(.LAT(4)) u4 (
    .clk(clk), .rst(u4_rst), .req0(u4_req0), .req1(u4_req1),
    .a0(u4_a0), .b0(u4_b0), .a1(u4_a1), .b1(u4_b1), .o0(u4_o0), .o1(u4_o1),
    .done0(u4_done0), .done1(u4_done1), .r0(u4_r0), .r1(u4_r1),
    .alu_a(u4_alu_a), .alu_b(u4_alu_b), .alu_o(u4_alu_o), .alu_p(u4_alu_p),
    .busy(u4_busy), .ops(u4_ops)
  );

  // Scoreboard entries: {port, result, ops after completion}
  logic [16:0] sb1[$];
  logic [16:0] sb4[$];
  logic [16:0] e1, e4;
  logic [7:0]  exp_ops1, exp_ops4;

  always @(negedge clk) begin
    if (u1_done0 === 1'b1 || u1_done1 === 1'b1) begin
      check("u1 done exclusive", 32'(u1_done0 & u1_done1), 32'd0);
      if (sb1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL u1 unexpected done: got done0=%0b done1=%0b expected none", u1_done0, u1_done1);
      end else begin
        e1 = sb1.pop_front();
        check("u1 done port", 32'(u1_done1), 32'(e1[16]));
        check("u1 result", 32'(e1[16] ? u1_r1 : u1_r0), 32'(e1[15:8]));
        check("u1 ops", 32'(u1_ops), 32'(e1[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (u4_done0 === 1'b1 || u4_done1 === 1'b1) begin
      check("u4 done exclusive", 32'(u4_done0 & u4_done1), 32'd0);
      if (sb4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL u4 unexpected done: got done0=%0b done1=%0b expected none", u4_done0, u4_done1);
      end else begin
        e4 = sb4.pop_front();
        check("u4 done port", 32'(u4_done1), 32'(e4[16]));
        check("u4 result", 32'(e4[16] ? u4_r1 : u4_r0), 32'(e4[15:8]));
        check("u4 ops", 32'(u4_ops), 32'(e4[7:0]));
      end
    end
  end

  task automatic wait_done1(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (u1_done0 || u1_done1) begin
        cyc = i;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL u1 wait done: got timeout expected done pulse");
  endtask

  task automatic wait_done4(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (u4_done0 || u4_done1) begin
        cyc = i;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL u4 wait done: got timeout expected done pulse");
  endtask

  // Contention vectors, hand-computed results
  logic [3:0] P0A[4] = '{4'h3, 4'hF, 4'h2, 4'hA};
  logic [3:0] P0B[4] = '{4'h5, 4'hF, 4'h7, 4'h5};
  logic [1:0] P0O[4] = '{2'd0, 2'd2, 2'd1, 2'd3};
  logic [7:0] P0R[4] = '{8'h08, 8'hE1, 8'hFB, 8'hA5};
  logic [3:0] P1A[4] = '{4'h9, 4'hC, 4'h7, 4'h1};
  logic [3:0] P1B[4] = '{4'h8, 4'h3, 4'h6, 4'hE};
  logic [1:0] P1O[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] P1R[4] = '{8'h11, 8'h09, 8'h2A, 8'h1E};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n0, n1, nd;
    logic [7:0] p_at4;
    logic [7:0] r_exp;
    u1_rst = 1'b1; u1_req0 = 1'b1; u1_req1 = 1'b1;
    u1_a0 = P0A[0]; u1_b0 = P0B[0]; u1_o0 = P0O[0];
    u1_a1 = P1A[0]; u1_b1 = P1B[0]; u1_o1 = P1O[0];
    u4_rst = 1'b1; u4_req0 = 1'b1; u4_req1 = 1'b1;
    u4_a0 = 4'h0; u4_b0 = 4'h0; u4_o0 = 2'd0;
    u4_a1 = 4'h0; u4_b1 = 4'h0; u4_o1 = 2'd0;
    exp_ops1 = 8'd0; exp_ops4 = 8'd0;

    // reset with both requests high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst u1 busy", 32'(u1_busy), 32'd0);
    check("rst u1 done", 32'({u1_done0, u1_done1}), 32'd0);
    check("rst u1 r0", 32'(u1_r0), 32'd0);
    check("rst u1 r1", 32'(u1_r1), 32'd0);
    check("rst u1 ops", 32'(u1_ops), 32'd0);
    check("rst u1 alu", 32'({u1_alu_a, u1_alu_b, u1_alu_o}), 32'd0);
    check("rst u4 busy", 32'(u4_busy), 32'd0);
    check("rst u4 alu", 32'({u4_alu_a, u4_alu_b, u4_alu_o}), 32'd0);

    // contention: 8 operations alternating 0,1,0,1,...
    for (int k = 0; k < 8; k++) begin
      exp_ops1 = exp_ops1 + 8'd1;
      r_exp = (k % 2 == 1) ? P1R[k / 2] : P0R[k / 2];
      sb1.push_back({(k % 2 == 1), r_exp, exp_ops1});
    end
    u1_rst = 1'b0;
    @(negedge clk);
    check("first grant busy", 32'(u1_busy), 32'd1);
    check("first grant alu", 32'({u1_alu_a, u1_alu_b, u1_alu_o}), 32'({4'h3, 4'h5, 2'd0}));
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      wait_done1(cyc);
      check("done period", 32'(cyc), (k == 0) ? 32'd1 : 32'd2);
      if (u1_done0) begin
        n0++;
        if (n0 < 4) begin u1_a0 = P0A[n0]; u1_b0 = P0B[n0]; u1_o0 = P0O[n0]; end
      end
      if (u1_done1) begin
        n1++;
        if (n1 < 4) begin u1_a1 = P1A[n1]; u1_b1 = P1B[n1]; u1_o1 = P1O[n1]; end
      end
      if (k == 7) begin u1_req0 = 1'b0; u1_req1 = 1'b0; end
    end
    check("ops after contention", 32'(u1_ops), 32'd8);

    // single op, LAT=1
    @(negedge clk); u1_rst = 1'b1;
    @(negedge clk); u1_rst = 1'b0;
    exp_ops1 = 8'd1;
    u1_req0 = 1'b1; u1_a0 = 4'h3; u1_b0 = 4'h5; u1_o0 = 2'd0;
    sb1.push_back({1'b0, 8'h08, 8'd1});
    @(negedge clk);
    check("single alu", 32'({u1_alu_a, u1_alu_b, u1_alu_o}), 32'({4'h3, 4'h5, 2'd0}));
    check("single busy c1", 32'(u1_busy), 32'd1);
    check("single done c1", 32'(u1_done0), 32'd0);
    @(negedge clk);
    check("single done c2", 32'(u1_done0), 32'd1);
    check("single busy c2", 32'(u1_busy), 32'd0);
    // req still high through the done cycle must not be re-granted
    @(negedge clk);
    check("done mask busy", 32'(u1_busy), 32'd0);
    u1_req0 = 1'b0;
    check("single r1 untouched", 32'(u1_r1), 32'd0);

    // 255 more completions wrap ops to 0
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      u1_a0 = 4'(i); u1_b0 = 4'(i * 7); u1_o0 = 2'(i);
      exp_ops1 = exp_ops1 + 8'd1;
      sb1.push_back({1'b0, alu_ref(u1_a0, u1_b0, u1_o0), exp_ops1});
      u1_req0 = 1'b1;
      wait_done1(cyc);
      u1_req0 = 1'b0;
    end
    check("ops wrap", 32'(u1_ops), 32'd0);

    // LAT=4 single request on port 1
    @(negedge clk);
    u4_req0 = 1'b0; u4_req1 = 1'b1; u4_rst = 1'b0;
    u4_a1 = 4'hB; u4_b1 = 4'h6; u4_o1 = 2'd2;
    exp_ops4 = 8'd1;
    sb4.push_back({1'b1, 8'h42, 8'd1});
    p_at4 = 8'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("lat4 busy", 32'(u4_busy), 32'd1);
      check("lat4 alu stable", 32'({u4_alu_a, u4_alu_b, u4_alu_o}), 32'({4'hB, 4'h6, 2'd2}));
      check("lat4 no early done", 32'(u4_done1), 32'd0);
      if (c == 4) p_at4 = u4_alu_p;
    end
    @(negedge clk);
    check("lat4 done1 c5", 32'(u4_done1), 32'd1);
    check("lat4 busy c5", 32'(u4_busy), 32'd0);
    check("lat4 r1 vs alu_p", 32'(u4_r1), 32'(p_at4));
    u4_req1 = 1'b0;

    // abort by reset in the second EXEC cycle
    @(negedge clk);
    u4_req1 = 1'b1; u4_a1 = 4'hC; u4_b1 = 4'hD; u4_o1 = 2'd0;
    @(negedge clk);
    check("abort busy c1", 32'(u4_busy), 32'd1);
    @(negedge clk);
    u4_rst = 1'b1; u4_req1 = 1'b0;
    @(negedge clk);
    check("abort idle", 32'(u4_busy), 32'd0);
    check("abort done", 32'({u4_done0, u4_done1}), 32'd0);
    check("abort ops", 32'(u4_ops), 32'd0);
    check("abort alu", 32'({u4_alu_a, u4_alu_b, u4_alu_o}), 32'd0);
    u4_rst = 1'b0;
    exp_ops4 = 8'd0;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (u4_done0 || u4_done1) nd++;
    end
    check("abort no done", 32'(nd), 32'd0);
    check("abort r1", 32'(u4_r1), 32'd0);

    // req0 dropped mid-EXEC still completes with the latched operands
    u4_req0 = 1'b1; u4_a0 = 4'h6; u4_b0 = 4'h9; u4_o0 = 2'd1;
    exp_ops4 = 8'd1;
    sb4.push_back({1'b0, 8'hFD, 8'd1});
    @(negedge clk);
    check("drop busy c1", 32'(u4_busy), 32'd1);
    @(negedge clk);
    u4_req0 = 1'b0; u4_a0 = 4'hF; u4_b0 = 4'hF; u4_o0 = 2'd3;
    wait_done4(cyc);
    check("drop done cycle", 32'(cyc), 32'd3);
    check("drop done0", 32'(u4_done0), 32'd1);
    check("drop alu held", 32'({u4_alu_a, u4_alu_b, u4_alu_o}), 32'({4'h6, 4'h9, 2'd1}));

    repeat (3) @(negedge clk);
    check("u1 scoreboard drained", 32'(sb1.size()), 32'd0);
    check("u4 scoreboard drained", 32'(sb4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
